// File: rtl/mem_arbiter_pkg.sv
// Shared processor constants: data-memory size and the arbiter port-select encoding.
package mem_arbiter_pkg;

    localparam int MAX_MEM_INDEX = 127;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_resp.sv
// Per-port completion registers: one-cycle rvalid pulse, captured read data and range error.
module mem_arb_resp
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt,
    input  logic              we,
    input  logic              in_range,
    input  logic [DATA_W-1:0] mrd,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt;
            err    <= gnt & ~in_range;
            // Writes and out-of-range reads complete with zero data; idle cycles hold.
            if (gnt) begin
                rdata <= (!we && in_range) ? mrd : '0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Handshake: pN_req is held with stable we/addr/wdata until pN_gnt; completion follows one cycle later on pN_rvalid.
module mem_arbiter #(
    parameter int MAX_MEM_INDEX = mem_arbiter_pkg::MAX_MEM_INDEX,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mwr,
    output logic              moe,
    output logic [ADDR_W-1:0] ma,
    output logic [DATA_W-1:0] mwd,
    input  logic [DATA_W-1:0] mrd,
    output logic              prio_dbg
);

    import mem_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAX_MEM_INDEX);

    logic              prio;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    // Port 0 wins when alone or when the pointer favours it; otherwise port 1 takes any request.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (p0_req && (!p1_req || prio == PORT0)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (p0_gnt) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else if (p1_gnt) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    assign any_gnt      = p0_gnt | p1_gnt;
    assign sel_in_range = (sel_addr >> 2) <= MAX_IDX;

    assign ma  = sel_addr;
    assign mwd = sel_wdata;
    assign mwr = any_gnt & sel_we & sel_in_range;
    assign moe = any_gnt & ~sel_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            prio <= PORT0;
        end else if (p0_gnt) begin
            prio <= PORT1;
        end else if (p1_gnt) begin
            prio <= PORT0;
        end
    end

    assign prio_dbg = prio;

    mem_arb_resp #(.DATA_W(DATA_W)) u_resp0 (
        .clock    (clock),
        .reset    (reset),
        .gnt      (p0_gnt),
        .we       (sel_we),
        .in_range (sel_in_range),
        .mrd      (mrd),
        .rvalid   (p0_rvalid),
        .rdata    (p0_rdata),
        .err      (p0_err)
    );

    mem_arb_resp #(.DATA_W(DATA_W)) u_resp1 (
        .clock    (clock),
        .reset    (reset),
        .gnt      (p1_gnt),
        .we       (sel_we),
        .in_range (sel_in_range),
        .mrd      (mrd),
        .rvalid   (p1_rvalid),
        .rdata    (p1_rdata),
        .err      (p1_err)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: external memory, per-cycle reference model and directed scenarios.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mwr, moe, prio_dbg;
    logic [31:0] ma, mwd, mrd;

    logic [31:0] mem [256];

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd), .prio_dbg(prio_dbg)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // External memory: combinational read, write lands at the clock edge.
    assign mrd = mem[ma[9:2]];
    always @(posedge clock) if (mwr) mem[ma[9:2]] <= mwd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: priority pointer, completion registers and memory image.
    int          m_prio;
    bit          m_known = 0;
    logic        m_rvalid [2];
    logic        m_err    [2];
    logic [31:0] m_rdata  [2];
    logic [31:0] ref_mem  [int];

    function automatic logic [31:0] ref_read(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    initial begin
        logic        req [2];
        logic        we  [2];
        logic [31:0] adr [2];
        logic [31:0] wd  [2];
        int          g, idx;
        bit          inr;
        forever begin
            @(negedge clock);
            req[0] = p0_req; we[0] = p0_we; adr[0] = p0_addr; wd[0] = p0_wdata;
            req[1] = p1_req; we[1] = p1_we; adr[1] = p1_addr; wd[1] = p1_wdata;
            if (reset)               g = -1;
            else if (req[0] && req[1]) g = m_prio;
            else if (req[0])         g = 0;
            else if (req[1])         g = 1;
            else                     g = -1;
            idx = (g >= 0) ? int'(adr[g] >> 2) : 0;
            inr = (idx <= 127);
            check("m_gnt0", {31'b0, p0_gnt}, {31'b0, g == 0});
            check("m_gnt1", {31'b0, p1_gnt}, {31'b0, g == 1});
            check("m_ma",   ma,  (g >= 0) ? adr[g] : 32'h0);
            check("m_mwd",  mwd, (g >= 0) ? wd[g]  : 32'h0);
            check("m_mwr",  {31'b0, mwr}, {31'b0, g >= 0 && we[g] && inr});
            check("m_moe",  {31'b0, moe}, {31'b0, g >= 0 && !we[g]});
            if (m_known) begin
                check("m_prio",    {31'b0, prio_dbg},  32'(m_prio));
                check("m_rvalid0", {31'b0, p0_rvalid}, {31'b0, m_rvalid[0]});
                check("m_rvalid1", {31'b0, p1_rvalid}, {31'b0, m_rvalid[1]});
                check("m_err0",    {31'b0, p0_err},    {31'b0, m_err[0]});
                check("m_err1",    {31'b0, p1_err},    {31'b0, m_err[1]});
                check("m_rdata0",  p0_rdata, m_rdata[0]);
                check("m_rdata1",  p1_rdata, m_rdata[1]);
            end
            // Advance the model to the state after the coming edge.
            if (reset) begin
                m_prio = 0;
                m_known = 1;
                for (int p = 0; p < 2; p++) begin
                    m_rvalid[p] = 0; m_err[p] = 0; m_rdata[p] = 0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    m_rvalid[p] = (g == p);
                    m_err[p]    = (g == p) && !inr;
                    if (g == p) m_rdata[p] = (!we[p] && inr) ? ref_read(idx) : 32'h0;
                end
                if (g >= 0) begin
                    m_prio = 1 - g;
                    if (we[g] && inr) ref_mem[idx] = wd[g];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        neg();
        check("rst_prio",    {31'b0, prio_dbg},  32'h0);
        check("rst_rvalid0", {31'b0, p0_rvalid}, 32'h0);
        check("rst_rdata1",  p1_rdata, 32'h0);
        tick();

        // p0 write then read of 0x10
        drive(0, 1, 1, 32'h10, 32'hDEADBEEF);
        neg();
        check("wr_gnt", {31'b0, p0_gnt}, 32'h1);
        check("wr_mwr", {31'b0, mwr}, 32'h1);
        check("wr_ma",  ma, 32'h10);
        tick();
        drive(0, 1, 0, 32'h10, 32'h0);
        neg();
        check("rd_gnt",     {31'b0, p0_gnt}, 32'h1);
        check("rd_moe",     {31'b0, moe}, 32'h1);
        check("wr_rvalid",  {31'b0, p0_rvalid}, 32'h1);
        check("wr_err",     {31'b0, p0_err}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        neg();
        check("rd_rvalid", {31'b0, p0_rvalid}, 32'h1);
        check("rd_rdata",  p0_rdata, 32'hDEADBEEF);
        check("rd_err",    {31'b0, p0_err}, 32'h0);
        tick();

        // Both ports reading for three cycles after reset
        do_reset();
        drive(0, 1, 0, 32'h20, 32'h0);
        drive(1, 1, 0, 32'h24, 32'h0);
        neg();
        check("rr0_gnt0", {31'b0, p0_gnt}, 32'h1);
        check("rr0_gnt1", {31'b0, p1_gnt}, 32'h0);
        check("rr0_prio", {31'b0, prio_dbg}, 32'h0);
        tick();
        neg();
        check("rr1_gnt1",   {31'b0, p1_gnt}, 32'h1);
        check("rr1_rvalid", {31'b0, p0_rvalid}, 32'h1);
        check("rr1_prio",   {31'b0, prio_dbg}, 32'h1);
        tick();
        neg();
        check("rr2_gnt0",   {31'b0, p0_gnt}, 32'h1);
        check("rr2_rvalid", {31'b0, p1_rvalid}, 32'h1);
        check("rr2_prio",   {31'b0, prio_dbg}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        neg();
        check("rr3_rvalid0", {31'b0, p0_rvalid}, 32'h1);
        check("rr3_rdata0",  p0_rdata, init_word(8));
        check("rr3_prio",    {31'b0, prio_dbg}, 32'h1);
        tick();

        // p1 out-of-range write and read at index 128
        drive(1, 1, 1, 32'h200, 32'h1);
        neg();
        check("oor_gnt", {31'b0, p1_gnt}, 32'h1);
        check("oor_mwr", {31'b0, mwr}, 32'h0);
        tick();
        drive(1, 1, 0, 32'h200, 32'h0);
        neg();
        check("oor_wr_rvalid", {31'b0, p1_rvalid}, 32'h1);
        check("oor_wr_err",    {31'b0, p1_err}, 32'h1);
        tick();
        drive(1, 0, 0, 0, 0);
        neg();
        check("oor_rd_err",   {31'b0, p1_err}, 32'h1);
        check("oor_rd_rdata", p1_rdata, 32'h0);
        tick();

        // Simultaneous write (p0) and read (p1) of 0x4
        drive(0, 1, 1, 32'h4, 32'hCAFEF00D);
        drive(1, 1, 0, 32'h4, 32'h0);
        neg();
        check("wr_rd_prio", {31'b0, prio_dbg}, 32'h0);
        check("wr_rd_gnt0", {31'b0, p0_gnt}, 32'h1);
        check("wr_rd_gnt1", {31'b0, p1_gnt}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        neg();
        check("wr_rd_gnt1b", {31'b0, p1_gnt}, 32'h1);
        tick();
        drive(1, 0, 0, 0, 0);
        neg();
        check("wr_rd_rdata", p1_rdata, 32'hCAFEF00D);
        tick();

        // Reset lands in the cycle p1 would be granted
        drive(0, 1, 0, 32'hC, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 32'h8, 32'h12345678);
        reset = 1'b1;
        neg();
        check("rst_gnt1", {31'b0, p1_gnt}, 32'h0);
        check("rst_mwr",  {31'b0, mwr}, 32'h0);
        check("rst_prio_pre", {31'b0, prio_dbg}, 32'h1);
        tick();
        reset = 1'b0;
        neg();
        check("rst_prio_post", {31'b0, prio_dbg}, 32'h0);
        check("rst_no_rvalid", {31'b0, p1_rvalid}, 32'h0);
        check("rerq_gnt",      {31'b0, p1_gnt}, 32'h1);
        check("rerq_mwr",      {31'b0, mwr}, 32'h1);
        tick();
        drive(1, 1, 0, 32'h8, 32'h0);
        tick();
        drive(1, 0, 0, 0, 0);
        neg();
        check("rerq_rdata", p1_rdata, 32'h12345678);
        tick();

        // Back-to-back p1 reads
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 32'(i * 4), 32'h0);
            neg();
            check("b2b_gnt", {31'b0, p1_gnt}, 32'h1);
            tick();
        end
        drive(1, 0, 0, 0, 0);
        neg();
        check("b2b_last_rvalid", {31'b0, p1_rvalid}, 32'h1);
        tick();

        // Idle after a p0 access: outputs quiet, pointer held at port 1
        drive(0, 1, 0, 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            neg();
            check("idle_prio", {31'b0, prio_dbg}, 32'h1);
            check("idle_ma",   ma, 32'h0);
            check("idle_mwd",  mwd, 32'h0);
            check("idle_mwr",  {31'b0, mwr}, 32'h0);
            check("idle_moe",  {31'b0, moe}, 32'h0);
            check("idle_rv0",  {31'b0, p0_rvalid}, 32'h0);
            check("idle_rv1",  {31'b0, p1_rvalid}, 32'h0);
            tick();
        end

        neg();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
